ahb_lite_master: RTL and testbench
==================================

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL provide parameter HPROT_VAL, default 4'b0011, constant HPROT value (non-cacheable, privileged, data).
REQ-002 SHALL provide parameter CNT_W, default 16, width of xfer_count.
REQ-003 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 HRESET  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request from local logic.
REQ-006 cmd_ready  output  1  block accepts command this cycle.
REQ-007 cmd_write  input  1  1=write, 0=read.
REQ-008 cmd_addr  input  32  transfer address.
REQ-009 cmd_size  input  3  000=8b, 001=16b, 010=32b; others illegal.
REQ-010 cmd_wdata  input  32  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed.
REQ-013 rsp_rdata  output  32  read data (0 for writes and rejected commands).
REQ-014 rsp_status  output  2  00=OKAY, 01=bus ERROR, 10=rejected (illegal size or misaligned).
REQ-015 HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HBURST 3, HMASTLOCK 1, HPROT 4, HWDATA 32  outputs  AHB-Lite master signals.
REQ-016 HRDATA  input  32; HREADY  input  1; HRESP  input  2 (2'b01=ERROR, all other values OKAY).
REQ-017 xfer_count  output  CNT_W  count of completed bus transfers.

Function
REQ-018 HBURST SHALL be 3'b000 (SINGLE), HMASTLOCK 0 and HPROT HPROT_VAL at all times.
REQ-019 FSM SHALL have states S_IDLE, S_ADDR, S_DATA, S_RESP.
REQ-020 cmd_ready SHALL be 1 only in S_IDLE; a command is accepted on the edge where cmd_valid && cmd_ready, latching write, addr, size and wdata.
REQ-021 Accepted command with cmd_size > 3'b010, or addr[0]!=0 at size 001, or addr[1:0]!=0 at size 010, SHALL go directly to S_RESP with rsp_status=10, rsp_rdata=0 and no bus activity.
REQ-022 Legal command SHALL go S_IDLE -> S_ADDR.
REQ-023 In S_ADDR: HTRANS=2'b10 (NONSEQ); HADDR, HWRITE and HSIZE SHALL carry the latched values; move to S_DATA on an edge with HREADY=1, otherwise hold all address-phase outputs stable.
REQ-024 In S_DATA: HTRANS=2'b00 (IDLE); HWDATA SHALL carry the latched wdata (0 for reads) and stay stable until completion.
REQ-025 S_DATA SHALL complete on the first edge with HREADY=1, capturing HRDATA (reads only) and rsp_status = (HRESP==01) ? 01 : 00, then go to S_RESP.
REQ-026 A first ERROR cycle (HRESP=01, HREADY=0) SHALL keep HTRANS IDLE and wait; completion uses HRESP sampled on the HREADY=1 edge.
REQ-027 In S_RESP rsp_valid=1 with rsp_rdata and rsp_status held stable; on the edge with rsp_ready=1 go to S_IDLE.
REQ-028 Outside S_ADDR, HTRANS SHALL be IDLE; HADDR/HWRITE/HSIZE SHALL hold their last values.
REQ-029 Zero-wait latency: command accepted at edge N, NONSEQ driven in cycle N+1, data phase in N+2, rsp_valid=1 from N+3; each HREADY=0 cycle adds one cycle.
REQ-030 Back-to-back throughput SHALL be one transfer per 4 cycles minimum (no address/data overlap).
REQ-031 xfer_count SHALL increment by 1 on each S_DATA completion (OKAY or ERROR), never for rejected commands, and wrap from all-ones to 0.
REQ-032 cmd_valid while not in S_IDLE SHALL be ignored (cmd_ready=0).

Reset
REQ-033 On an edge with HRESET=1: state S_IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_status=00, xfer_count=0; cmd_ready=1 in the first cycle after reset.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer with no response generated; HTRANS=IDLE from the cycle after the reset edge.

Verification
REQ-035 Read, size 010, addr 0x4000_0004, zero-wait slave returns 0xDEAD_BEEF -> NONSEQ in cycle N+1, rsp_valid in N+3 with rsp_rdata=0xDEAD_BEEF, rsp_status=00, xfer_count=1.
REQ-036 Write 0x1234_5678 to 0x4000_0000, slave holds HREADY=0 for 3 data-phase cycles -> HWDATA stable through all wait cycles, rsp_valid at N+6, rsp_status=00, rsp_rdata=0.
REQ-037 Read, slave answers ERROR (HREADY=0 then HREADY=1, HRESP=01) -> rsp_status=01, xfer_count increments, HTRANS IDLE throughout.
REQ-038 Size 010 at addr 0x...02 and size 011 at any addr -> rsp_status=10, HTRANS never NONSEQ, xfer_count unchanged.
REQ-039 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp_valid and data held stable, cmd_ready=0, no new NONSEQ; HRESET pulsed during S_DATA -> all outputs at reset values, no response.

Source files
------------

// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master
//
// Turns single local commands into single AHB-Lite transfers. Each command
// is checked for a legal size and alignment on acceptance; illegal ones are
// answered immediately with a "rejected" status and never reach the bus.
// Legal ones run one address phase (NONSEQ) and one data phase. Address and
// data phases never overlap, so the bus sees at most one transfer every four
// cycles.
//
// State table
//   state  | meaning
//   S_IDLE | ready for a command (cmd_ready=1)
//   S_ADDR | address phase, HTRANS=NONSEQ, waits for HREADY
//   S_DATA | data phase, HTRANS=IDLE, waits for HREADY to complete
//   S_RESP | response presented on rsp_*, waits for rsp_ready
//
// Ports
//   HCLK, HRESET            clock, synchronous active-high reset
//   cmd_valid/ready         command handshake
//   cmd_write/addr/size     command attributes (size 0=8b, 1=16b, 2=32b)
//   cmd_wdata               write data
//   rsp_valid/ready         response handshake
//   rsp_rdata, rsp_status   read data, status (00 OKAY, 01 ERROR, 10 rejected)
//   H*                      AHB-Lite master signals
//   xfer_count              completed bus transfers, wraps
// ---------------------------------------------------------------------------
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011,
    parameter int         CNT_W     = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [2:0]       cmd_size,
    input  logic [31:0]      cmd_wdata,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic [1:0]       rsp_status,

    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic             HMASTLOCK,
    output logic [3:0]       HPROT,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic [1:0]       HRESP,

    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    localparam logic [1:0] ST_OKAY   = 2'b00;
    localparam logic [1:0] ST_ERROR  = 2'b01;
    localparam logic [1:0] ST_REJECT = 2'b10;

    state_t            state_q, state_d;
    logic [31:0]       haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic [CNT_W-1:0]  xfer_count_q, xfer_count_d;

    logic              cmd_accept;
    logic              cmd_illegal;
    logic              data_done;

    // Size above 32 bits, or an address not aligned to the transfer size.
    always_comb begin
        cmd_illegal = 1'b0;
        case (cmd_size)
            3'b000:  cmd_illegal = 1'b0;
            3'b001:  cmd_illegal = cmd_addr[0];
            3'b010:  cmd_illegal = (cmd_addr[1:0] != 2'b00);
            default: cmd_illegal = 1'b1;
        endcase
    end

    assign cmd_accept = cmd_valid && (state_q == S_IDLE);
    assign data_done  = (state_q == S_DATA) && HREADY;

    // -----------------------------------------------------------------------
    // State register and datapath flops
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= S_IDLE;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= '0;
            hwdata_q     <= '0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= ST_OKAY;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
            hwdata_q     <= hwdata_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_illegal ? S_RESP : S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next values
    // -----------------------------------------------------------------------
    // The bus-facing address/control flops are only loaded for legal commands,
    // so a rejected command leaves HADDR/HWRITE/HSIZE/HWDATA untouched.
    // HWDATA is loaded at acceptance: it is then already stable for the whole
    // data phase, including any wait states.
    always_comb begin
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hsize_d      = hsize_q;
        hwdata_d     = hwdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;
        xfer_count_d = xfer_count_q;

        if (cmd_accept) begin
            if (cmd_illegal) begin
                rsp_rdata_d  = '0;
                rsp_status_d = ST_REJECT;
            end else begin
                haddr_d  = cmd_addr;
                hwrite_d = cmd_write;
                hsize_d  = cmd_size;
                hwdata_d = cmd_write ? cmd_wdata : 32'h0;
            end
        end

        // An ERROR seen with HREADY=0 is only the first cycle of the
        // two-cycle error response; the status is taken on the HREADY edge.
        if (data_done) begin
            rsp_rdata_d  = hwrite_q ? 32'h0 : HRDATA;
            rsp_status_d = (HRESP == 2'b01) ? ST_ERROR : ST_OKAY;
            xfer_count_d = xfer_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        HTRANS    = TRANS_IDLE;
        case (state_q)
            S_IDLE:  cmd_ready = 1'b1;
            S_ADDR:  HTRANS    = TRANS_NONSEQ;
            S_DATA:  HTRANS    = TRANS_IDLE;
            S_RESP:  rsp_valid = 1'b1;
            default: HTRANS    = TRANS_IDLE;
        endcase
    end

    assign HADDR      = haddr_q;
    assign HWRITE     = hwrite_q;
    assign HSIZE      = hsize_q;
    assign HWDATA     = hwdata_q;
    assign HBURST     = 3'b000;
    assign HMASTLOCK  = 1'b0;
    assign HPROT      = HPROT_VAL;

    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_status = rsp_status_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
module tb_ahb_lite_master;

    localparam int TB_CNT_W = 3;

    logic                HCLK = 1'b0;
    logic                HRESET;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [31:0]         cmd_addr;
    logic [2:0]          cmd_size;
    logic [31:0]         cmd_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_rdata;
    logic [1:0]          rsp_status;
    logic [31:0]         HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [2:0]          HBURST;
    logic                HMASTLOCK;
    logic [3:0]          HPROT;
    logic [31:0]         HWDATA;
    logic [31:0]         HRDATA;
    logic                HREADY;
    logic [1:0]          HRESP;
    logic [TB_CNT_W-1:0] xfer_count;

    int checks = 0;
    int errors = 0;
    logic [TB_CNT_W-1:0] exp_cnt = '0;

    ahb_lite_master #(
        .HPROT_VAL (4'b0011),
        .CNT_W     (TB_CNT_W)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_size   (cmd_size),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HMASTLOCK  (HMASTLOCK),
        .HPROT      (HPROT),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .xfer_count (xfer_count)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs are
    // sampled 1 ns after it.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_cmd(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_wdata = wd;
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_after_consume", {31'b0, rsp_valid}, 32'd0);
        chk("cmd_ready_after_consume", {31'b0, cmd_ready}, 32'd1);
    endtask

    // Zero-wait transfer or rejected command, from S_IDLE to response check.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd, input logic [31:0] slv,
                        input logic rej, input logic [1:0] exp_st, input logic [31:0] exp_rd);
        drive_cmd(wr, a, sz, wd);
        chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        if (!rej) begin
            chk({tag, "_htrans_nonseq"}, {30'b0, HTRANS}, 32'd2);
            chk({tag, "_haddr"}, HADDR, a);
            chk({tag, "_hwrite"}, {31'b0, HWRITE}, {31'b0, wr});
            chk({tag, "_hsize"}, {29'b0, HSIZE}, {29'b0, sz});
            chk({tag, "_rsp_valid_early"}, {31'b0, rsp_valid}, 32'd0);
            HREADY = 1'b1;
            step();
            chk({tag, "_htrans_data"}, {30'b0, HTRANS}, 32'd0);
            chk({tag, "_hwdata"}, HWDATA, wr ? wd : 32'h0);
            HRDATA = slv;
            step();
            HRDATA = 32'h0;
            exp_cnt++;
        end else begin
            chk({tag, "_htrans_idle"}, {30'b0, HTRANS}, 32'd0);
        end
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, "_rsp_status"}, {30'b0, rsp_status}, {30'b0, exp_st});
        chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_xfer_count"}, {29'b0, xfer_count}, {29'b0, exp_cnt});
        chk({tag, "_htrans_resp"}, {30'b0, HTRANS}, 32'd0);
        consume_rsp();
    endtask

    initial begin
        HRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 2'b00;
        step();
        step();
        HRESET = 1'b0;

        // Reset state and constant bus attributes
        chk("rst_htrans", {30'b0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_hwrite", {31'b0, HWRITE}, 32'd0);
        chk("rst_hsize", {29'b0, HSIZE}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_status", {30'b0, rsp_status}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_xfer_count", {29'b0, xfer_count}, 32'd0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("hburst", {29'b0, HBURST}, 32'd0);
        chk("hmastlock", {31'b0, HMASTLOCK}, 32'd0);
        chk("hprot", {28'b0, HPROT}, 32'h3);

        // Zero-wait 32-bit read
        xfer("rd32", 1'b0, 32'h4000_0004, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'hDEAD_BEEF);

        // Write with three data-phase wait states
        drive_cmd(1'b1, 32'h4000_0000, 3'b010, 32'h1234_5678);
        step();
        cmd_valid = 1'b0;
        chk("wr_htrans_nonseq", {30'b0, HTRANS}, 32'd2);
        chk("wr_hwrite", {31'b0, HWRITE}, 32'd1);
        HREADY = 1'b1;
        step();
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_wait_hwdata", HWDATA, 32'h1234_5678);
            chk("wr_wait_htrans", {30'b0, HTRANS}, 32'd0);
            chk("wr_wait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            step();
        end
        HREADY = 1'b1;
        chk("wr_last_hwdata", HWDATA, 32'h1234_5678);
        step();
        exp_cnt++;
        chk("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("wr_rsp_status", {30'b0, rsp_status}, 32'd0);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("wr_xfer_count", {29'b0, xfer_count}, {29'b0, exp_cnt});
        consume_rsp();

        // Read with two-cycle ERROR response
        drive_cmd(1'b0, 32'h4000_0008, 3'b010, 32'h0);
        step();
        cmd_valid = 1'b0;
        chk("err_htrans_nonseq", {30'b0, HTRANS}, 32'd2);
        HREADY = 1'b1;
        step();
        HREADY = 1'b0;
        HRESP  = 2'b01;
        chk("err_htrans_c1", {30'b0, HTRANS}, 32'd0);
        step();
        HREADY = 1'b1;
        chk("err_htrans_c2", {30'b0, HTRANS}, 32'd0);
        chk("err_rsp_valid_early", {31'b0, rsp_valid}, 32'd0);
        step();
        HRESP = 2'b00;
        exp_cnt++;
        chk("err_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("err_rsp_status", {30'b0, rsp_status}, 32'd1);
        chk("err_xfer_count", {29'b0, xfer_count}, {29'b0, exp_cnt});
        chk("err_htrans_resp", {30'b0, HTRANS}, 32'd0);
        consume_rsp();

        // Rejected commands and alignment boundaries
        xfer("rej_mis32", 1'b0, 32'h4000_0002, 3'b010, 32'h0, 32'h0, 1'b1, 2'b10, 32'h0);
        xfer("rej_size3", 1'b1, 32'h4000_0000, 3'b011, 32'hFFFF_FFFF, 32'h0, 1'b1, 2'b10, 32'h0);
        xfer("rej_mis16", 1'b0, 32'h4000_0001, 3'b001, 32'h0, 32'h0, 1'b1, 2'b10, 32'h0);
        xfer("rej_size7", 1'b0, 32'h4000_0000, 3'b111, 32'h0, 32'h0, 1'b1, 2'b10, 32'h0);
        xfer("ok16_a2", 1'b0, 32'h4000_0002, 3'b001, 32'h0, 32'h0000_A55A, 1'b0, 2'b00, 32'h0000_A55A);
        xfer("ok8_odd", 1'b1, 32'h4000_0003, 3'b000, 32'h0000_00C3, 32'h0, 1'b0, 2'b00, 32'h0);

        // Response back-pressure while a new command is offered
        drive_cmd(1'b0, 32'h4000_0010, 3'b010, 32'h0);
        step();
        cmd_valid = 1'b0;
        HREADY = 1'b1;
        step();
        HRDATA = 32'hCAFE_F00D;
        step();
        HRDATA = 32'h0;
        exp_cnt++;
        drive_cmd(1'b1, 32'h4000_0020, 3'b010, 32'h5555_AAAA);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
            chk("bp_rsp_status", {30'b0, rsp_status}, 32'd0);
            chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("bp_htrans", {30'b0, HTRANS}, 32'd0);
            step();
        end
        cmd_valid = 1'b0;
        chk("bp_xfer_count", {29'b0, xfer_count}, {29'b0, exp_cnt});
        consume_rsp();
        step();
        chk("bp_no_stale_nonseq", {30'b0, HTRANS}, 32'd0);

        // Counter wrap: 8 more transfers on a 3-bit counter
        for (int i = 0; i < 8; i++) begin
            xfer("wrap", 1'b0, 32'h4000_0100 + 32'(i * 4), 3'b010, 32'h0,
                 32'h1000_0000 + 32'(i), 1'b0, 2'b00, 32'h1000_0000 + 32'(i));
        end

        // Reset during the data phase abandons the transfer
        drive_cmd(1'b1, 32'h4000_0040, 3'b010, 32'h8765_4321);
        step();
        cmd_valid = 1'b0;
        HREADY = 1'b1;
        step();
        HREADY = 1'b0;
        chk("rstmid_in_data", HWDATA, 32'h8765_4321);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        HREADY = 1'b1;
        exp_cnt = '0;
        chk("rstmid_htrans", {30'b0, HTRANS}, 32'd0);
        chk("rstmid_haddr", HADDR, 32'd0);
        chk("rstmid_hwdata", HWDATA, 32'd0);
        chk("rstmid_hwrite", {31'b0, HWRITE}, 32'd0);
        chk("rstmid_xfer_count", {29'b0, xfer_count}, 32'd0);
        chk("rstmid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rstmid_no_rsp", {31'b0, rsp_valid}, 32'd0);
            chk("rstmid_idle_bus", {30'b0, HTRANS}, 32'd0);
            step();
        end

        // Normal operation after the mid-transfer reset
        xfer("post_rst", 1'b0, 32'h4000_0004, 3'b010, 32'h0, 32'h0BAD_F00D, 1'b0, 2'b00, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
